// File: rtl/obc_shift_accumulator.sv
// OBC shift-accumulator: sums four ROM partial words per bit slice, weights them
// LSB first, subtracts the MSB slice and adds the offset to form one DFT coefficient.
//
// state | meaning
// IDLE  | waiting for start; result holds the last coefficient
// ACCUM | consuming bit slices on in_valid, busy high
module obc_shift_accumulator #(
  parameter int N_BITS = 8,
  parameter int ACC_W  = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [31:0]      rom0,
  input  logic [31:0]      rom1,
  input  logic [31:0]      rom2,
  input  logic [31:0]      rom3,
  input  logic [31:0]      offset_in,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             out_valid
);

  localparam int CNT_W = $clog2(N_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      offset_q;

  logic [33:0]      slice_sum;
  logic [ACC_W-1:0] slice_ext;
  logic [ACC_W-1:0] slice_shl;
  logic [ACC_W-1:0] offset_ext;

  // 34 bits holds the exact sum of four signed 32-bit words
  assign slice_sum  = {{2{rom0[31]}}, rom0} + {{2{rom1[31]}}, rom1}
                    + {{2{rom2[31]}}, rom2} + {{2{rom3[31]}}, rom3};
  assign slice_ext  = {{(ACC_W-34){slice_sum[33]}}, slice_sum};
  assign slice_shl  = slice_ext << cnt;
  assign offset_ext = {{(ACC_W-32){offset_q[31]}}, offset_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      offset_q  <= '0;
      busy      <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            busy     <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            offset_q <= offset_in;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              // MSB slice carries negative weight in two's-complement OBC
              result    <= acc - slice_shl + offset_ext;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
              state     <= IDLE;
            end else begin
              acc <= acc + slice_shl;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Scoreboard bench for obc_shift_accumulator: expected coefficients are queued at
// start and compared when out_valid pulses; timing and busy are checked inline.
module tb_obc_shift_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] rom0 = '0, rom1 = '0, rom2 = '0, rom3 = '0;
  logic [31:0] offset_in = '0;
  logic        busy;
  logic [41:0] result;
  logic        out_valid;

  obc_shift_accumulator #(.N_BITS(8), .ACC_W(42)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .rom0(rom0), .rom1(rom1), .rom2(rom2), .rom3(rom3),
    .offset_in(offset_in), .busy(busy), .result(result), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ov_count = 0;
  logic [41:0] exp_q[$];
  logic [41:0] held = '0;
  logic        ov_prev = 1'b0;
  logic [31:0] rom_tab [8][4];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(posedge rst) held = '0;

  // Scoreboard / protocol monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        ov_count++;
        check_val("ov_single_pulse", ov_prev, 1'b0);
        if (exp_q.size() == 0) check_val("unexpected_out_valid", 1, 0);
        else check_val("result", result, exp_q.pop_front());
        held = result;
      end else begin
        check_val("result_stable", result, held);
      end
      ov_prev = out_valid;
    end else ov_prev = 1'b0;
  end

  function automatic logic [41:0] model(input logic [31:0] off);
    longint acc = 0;
    for (int i = 0; i < 8; i++) begin
      longint s = 0;
      for (int j = 0; j < 4; j++) s += longint'(signed'(rom_tab[i][j]));
      if (i == 7) acc -= s <<< 7;
      else        acc += s <<< i;
    end
    acc += longint'(signed'(off));
    return acc[41:0];
  endfunction

  task automatic fill_uniform(input logic [31:0] v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) rom_tab[i][j] = v;
  endtask

  // Called at a negedge; returns at the negedge where out_valid is expected
  // (or right after an abort).
  task automatic run(input logic [31:0] off, input logic [41:0] exp, input bit stalls,
                     input bit restart, input int abort_at);
    int s_cyc;
    int lat;
    if (abort_at < 0) exp_q.push_back(exp);
    start = 1'b1; offset_in = off;
    in_valid = 1'b1;
    rom0 = 32'h7FFF0000; rom1 = 32'h12345678; rom2 = 32'h0; rom3 = 32'h1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0; offset_in = 32'hDEADBEEF;
    lat = 9;
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_out_valid", out_valid, 1'b0);
        check_val("abort_result", result, 42'h0);
        #1 rst = 1'b0;
        return;
      end
      check_val("busy_accum", busy, 1'b1);
      in_valid = 1'b1;
      rom0 = rom_tab[i][0]; rom1 = rom_tab[i][1];
      rom2 = rom_tab[i][2]; rom3 = rom_tab[i][3];
      if (restart && i == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (stalls && (i == 2 || i == 5)) begin
        in_valid = 1'b0;
        rom0 = 32'hFFFFFFFF; rom1 = 32'h55555555;
        repeat (3) begin
          check_val("busy_stall", busy, 1'b1);
          @(negedge clk);
        end
        lat += 3;
      end
    end
    in_valid = 1'b0;
    check_val("out_valid_latency", out_valid, 1'b1);
    check_val("latency_edges", cyc - s_cyc, lat);
    check_val("busy_done", busy, 1'b0);
  endtask

  initial begin
    #12;
    check_val("reset_result", result, 42'h0);
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // uniform slices of 1
    fill_uniform(32'h1);
    run(32'h0, 42'h3FF_FFFF_FFFC, 0, 0, -1);
    repeat (2) @(negedge clk);

    // async reset between edges clears outputs with no clock
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_result", result, 42'h0);
    check_val("async_rst_busy", busy, 1'b0);
    check_val("async_rst_ov", out_valid, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);

    // LSB-only slice with negative offset
    fill_uniform(32'h0);
    for (int j = 0; j < 4; j++) rom_tab[0][j] = 32'h000B5050;
    run(32'hFFF4AFB0, 42'h021F0F0, 0, 0, -1);
    @(negedge clk);

    // MSB subtraction
    fill_uniform(32'h0);
    rom_tab[7][0] = 32'h00200000;
    run(32'h0, 42'h3FF_F000_0000, 0, 0, -1);
    @(negedge clk);

    // stalls plus ignored start mid-accumulation
    fill_uniform(32'h1);
    run(32'h0, 42'h3FF_FFFF_FFFC, 1, 1, -1);
    @(negedge clk);

    // reset after slice 4, then a clean recovery run
    run(32'h0, 42'h0, 0, 0, 5);
    repeat (12) @(negedge clk);
    check_val("no_ov_after_abort", ov_count, 4);
    run(32'h0, 42'h3FF_FFFF_FFFC, 0, 0, -1);

    // back-to-back: second start in the out_valid cycle, random data
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) rom_tab[i][j] = $urandom;
    begin
      logic [31:0] off;
      off = $urandom;
      run(off, model(off), 0, 0, -1);
      off = $urandom;
      run(off, model(off), 0, 0, -1);
    end
    // extreme negative words exercise full width
    fill_uniform(32'h80000000);
    run(32'h80000000, model(32'h80000000), 1, 0, -1);

    repeat (5) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 0);
    check_val("ov_total", ov_count, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obc_shift_accumulator.md
Name: obc_shift_accumulator

Overview:
- Downstream stage of the OBC ROM banks (e.g. the k=6 imaginary ROM) in the 16-point bit-serial DFT.
- Each cycle it takes the four 32-bit ROM partial words for one bit slice, sums them, and accumulates shift-weighted across N_BITS slices, LSB first.
- The MSB slice is subtracted, per OBC two's-complement weighting.
- It then adds the OBC offset term and presents one full-precision DFT output coefficient with a valid pulse.

Parameters:
- N_BITS, 8, number of bit slices per transform (input sample width); legal range 2..16.
- ACC_W, 42, accumulator/result width; must be at least 34+N_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a new accumulation; honoured only in IDLE.
- in_valid  input  1  rom0..rom3 carry the current bit slice this cycle.
- rom0  input  32  signed Q10.21 ROM word, pair select0.
- rom1  input  32  signed Q10.21 ROM word, pair select1.
- rom2  input  32  signed Q10.21 ROM word, pair select2.
- rom3  input  32  signed Q10.21 ROM word, pair select3.
- offset_in  input  32  signed Q10.21 OBC offset constant; sampled on the start cycle.
- busy  output  1  high in ACCUM.
- result  output  ACC_W  signed Q(ACC_W-22).21 accumulated coefficient; held until the next completion.
- out_valid  output  1  one-cycle pulse when result updates.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, acc=0, cnt=0, offset register=0, busy=0, result=0, out_valid=0. Assertion at any time, including mid-accumulation, aborts the operation. No out_valid follows the abort.
- slice_sum: rom0+rom1+rom2+rom3, each sign-extended to 34 bits. Exact, no saturation.
- States:
  - IDLE:
    - start=1 -> ACCUM; acc<=0, cnt<=0, offset register<=offset_in.
    - in_valid is ignored in IDLE.
    - The start cycle consumes no slice, even if in_valid=1.
  - ACCUM (busy=1):
    - On in_valid=1 with cnt<N_BITS-1: acc <= acc + (sext(slice_sum) << cnt); cnt <= cnt+1.
    - On in_valid=1 with cnt==N_BITS-1 (MSB slice): result <= acc - (sext(slice_sum) << (N_BITS-1)) + sext(offset register); out_valid<=1 on the following cycle's output (registered pulse, exactly one cycle); acc<=0, cnt<=0; -> IDLE.
    - in_valid=0: hold acc, cnt and state. Stalls of any length are allowed.
    - start=1 in ACCUM is ignored.
- Arithmetic: all math is ACC_W-bit two's complement, sign-extended, with no rounding or truncation. Overflow is impossible when ACC_W>=34+N_BITS.
- Latency:
  - result and out_valid are visible one clock after the edge that consumes the MSB slice.
  - Minimum start-to-out_valid: N_BITS+1 edges.
  - busy drops in the same cycle out_valid rises.
- Back-to-back: start may be asserted in the cycle out_valid=1 (state is already IDLE) and is accepted.
- out_valid is never asserted twice for one start. result is stable whenever out_valid=0.

Test Plan:
- Reset behaviour:
  - Stimulus: assert rst asynchronously between clock edges.
  - Required: result=0, out_valid=0, busy=0 immediately, with no clock edge needed.
- Uniform slices (N_BITS=8, offset_in=0):
  - Stimulus: start, then 8 consecutive slices with rom0..3=32'h00000001.
  - Required: result=4·127−4·128=−4, i.e. 42'h3FF_FFFF_FFFC; out_valid exactly once, 9 edges after start.
- LSB-only slice:
  - Stimulus: rom0..3=32'h000B5050 on slice 0, zeros on slices 1..7, offset_in=32'hFFF4AFB0.
  - Required: result=0x2D4140+sext(0xFFF4AFB0)=0x21F0F0.
- MSB subtraction:
  - Stimulus: slices 0..6 zero; slice 7 has rom0=32'h00200000 (1.0), others 0; offset 0.
  - Required: result=−(0x200000<<7)=−0x10000000.
- Stalls and ignored start:
  - Stimulus: scenario 2 with in_valid low for 3 cycles after slices 2 and 5; start pulsed again mid-ACCUM.
  - Required: identical result −4, one out_valid, busy high throughout.
- Mid-run reset and recovery:
  - Stimulus: rst asserted after slice 4, then start and a full scenario 2 run.
  - Required: no out_valid for the aborted run; the next run returns −4.
